// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
//
// Purpose: detects load-use hazards and inserts LOAD_LAT bubbles, selects EX
// operand forwarding, handles I-cache and D-cache stalls, and flushes IF/ID and
// ID/EX on an EX redirect. A redirect that arrives during an I-cache miss is
// held until the miss completes.
//
// Parameters: AW (register address width), LOAD_LAT (load-use bubbles, 1..3),
//             CNT_W (perf counter width).
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_id_*                ID-stage valid/opcode/sources
//   i_ex_*, i_mem_*, i_wb_* destination/regwrite info of later stages
//   i_ex_rs1/rs2          EX sources for forwarding
//   i_ex_redirect         taken branch/jump resolved in EX
//   i_icache_stall, i_dcache_stall  cache busy
//   o_*_en                stage-register enables
//   o_id_ex_bubble, o_if_id_flush, o_redirect_pending
//   o_fwd_rs1/rs2         00 regfile, 01 EX/MEM, 10 MEM/WB
//   o_stall_cycles, o_bubble_cnt, o_flush_cnt  perf counters
// Build option: define HAZARD_PERF_EN to implement the perf counters;
// otherwise the counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [6:0]       i_id_opcode,
  input  logic [AW-1:0]    i_id_rs1,
  input  logic [AW-1:0]    i_id_rs2,
  input  logic [AW-1:0]    i_ex_rd,
  input  logic             i_ex_memread,
  input  logic             i_ex_regwrite,
  input  logic [AW-1:0]    i_mem_rd,
  input  logic             i_mem_regwrite,
  input  logic [AW-1:0]    i_wb_rd,
  input  logic             i_wb_regwrite,
  input  logic [AW-1:0]    i_ex_rs1,
  input  logic [AW-1:0]    i_ex_rs2,
  input  logic             i_ex_redirect,
  input  logic             i_icache_stall,
  input  logic             i_dcache_stall,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_id_ex_bubble,
  output logic             o_if_id_flush,
  output logic             o_redirect_pending,
  output logic [1:0]       o_fwd_rs1,
  output logic [1:0]       o_fwd_rs2,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_bubble_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_WAIT    = 2'd1,
    REDIR_HOLD = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  localparam logic [1:0] LU_INIT  = 2'(LOAD_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;

  logic use_rs1, use_rs2, lu_hit;

  // Source-register usage per opcode.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (i_id_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      OP_R, OP_S, OP_B: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign lu_hit = i_ex_memread & i_ex_regwrite & i_id_valid & (i_ex_rd != '0) &
                  ((use_rs1 & (i_id_rs1 == i_ex_rd)) |
                   (use_rs2 & (i_id_rs2 == i_ex_rd)));

  // Control outputs and next state, highest priority first.
  always_comb begin
    o_pc_en            = 1'b1;
    o_if_id_en         = 1'b1;
    o_id_ex_en         = 1'b1;
    o_ex_mem_en        = 1'b1;
    o_mem_wb_en        = 1'b1;
    o_id_ex_bubble     = 1'b0;
    o_if_id_flush      = 1'b0;
    o_redirect_pending = (state_q == REDIR_HOLD);
    state_d            = state_q;
    lu_cnt_d           = lu_cnt_q;

    if (i_rst) begin
      o_pc_en            = 1'b0;
      o_if_id_en         = 1'b0;
      o_id_ex_en         = 1'b0;
      o_ex_mem_en        = 1'b0;
      o_mem_wb_en        = 1'b0;
      o_id_ex_bubble     = 1'b1;
      o_redirect_pending = 1'b0;
      state_d            = RUN;
      lu_cnt_d           = '0;
    end else if (i_dcache_stall) begin
      // Whole pipe frozen; state and lu_cnt hold.
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
    end else if (i_ex_redirect && (state_q != REDIR_HOLD)) begin
      // Redirect cancels any pending load-use bubbles.
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      lu_cnt_d       = '0;
      if (i_icache_stall) begin
        o_pc_en = 1'b0;
        state_d = REDIR_HOLD;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        REDIR_HOLD: begin
          o_id_ex_bubble = 1'b1;
          if (i_icache_stall) begin
            o_pc_en    = 1'b0;
            o_if_id_en = 1'b0;
          end else begin
            o_if_id_flush = 1'b1;
            state_d       = RUN;
          end
        end
        LU_WAIT: begin
          o_pc_en        = 1'b0;
          o_if_id_en     = 1'b0;
          o_id_ex_bubble = 1'b1;
          if (lu_cnt_q <= 2'd1) begin
            lu_cnt_d = '0;
            state_d  = RUN;
          end else begin
            lu_cnt_d = lu_cnt_q - 2'd1;
          end
        end
        RUN: begin
          if (lu_hit) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d  = LU_WAIT;
              lu_cnt_d = LU_INIT;
            end
          end else if (i_icache_stall) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_bubble = 1'b1;
          end
        end
        default: begin
          state_d  = RUN;
          lu_cnt_d = '0;
        end
      endcase
    end
  end

  // Forwarding selects; MEM has priority over WB.
  always_comb begin
    o_fwd_rs1 = 2'b00;
    o_fwd_rs2 = 2'b00;
    if (!i_rst) begin
      if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs1))
        o_fwd_rs1 = 2'b01;
      else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs1))
        o_fwd_rs1 = 2'b10;
      if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs2))
        o_fwd_rs2 = 2'b01;
      else if (i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs2))
        o_fwd_rs2 = 2'b10;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;
  assign o_stall_cycles = stall_q;
  assign o_bubble_cnt   = bubble_q;
  assign o_flush_cnt    = flush_q;
`else
  assign o_stall_cycles = '0;
  assign o_bubble_cnt   = '0;
  assign o_flush_cnt    = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
`ifdef HAZARD_PERF_EN
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
`ifdef HAZARD_PERF_EN
      stall_q  <= stall_q  + CNT_W'(!o_pc_en);
      bubble_q <= bubble_q + CNT_W'(o_id_ex_bubble);
      flush_q  <= flush_q  + CNT_W'(o_if_id_flush);
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int LL = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [6:0]    id_opcode;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
  logic          ex_memread, ex_regwrite, mem_regwrite, wb_regwrite;
  logic          ex_redirect, icache_stall, dcache_stall;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          bubble, flush, pending;
  logic [1:0]    fwd1, fwd2;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  hazard_ctrl #(.AW(AW), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_valid(id_valid), .i_id_opcode(id_opcode),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_ex_rd(ex_rd), .i_ex_memread(ex_memread), .i_ex_regwrite(ex_regwrite),
    .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite),
    .i_wb_rd(wb_rd), .i_wb_regwrite(wb_regwrite),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
    .i_ex_redirect(ex_redirect),
    .i_icache_stall(icache_stall), .i_dcache_stall(dcache_stall),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
    .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
    .o_id_ex_bubble(bubble), .o_if_id_flush(flush),
    .o_redirect_pending(pending),
    .o_fwd_rs1(fwd1), .o_fwd_rs2(fwd2),
    .o_stall_cycles(stall_cnt), .o_bubble_cnt(bubble_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: number of load-use bubbles still owed after the current
  // cycle, whether a redirect is parked behind an I-miss, and counter totals.
  int          m_left = 0;
  bit          m_hold = 0;
  logic [CW-1:0] m_stall = '0, m_bub = '0, m_fl = '0;

  // Observed-event tallies for the directed scenarios.
  int pc_low_seen  = 0;
  int pend_seen    = 0;

  localparam logic [6:0] OPS [8] = '{7'b0110111, 7'b0010111, 7'b1101111,
                                     7'b0110011, 7'b0100011, 7'b1100011,
                                     7'b0000011, 7'b0010011};

  function automatic bit uses(input logic [6:0] op, input int which);
    bit none, both;
    none = (op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b1101111);
    both = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    if (none) return 1'b0;
    if (which == 1) return 1'b1;
    return both;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_opcode = 7'b0010011; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; ex_memread = 0; ex_regwrite = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_redirect = 0; icache_stall = 0; dcache_stall = 0;
  endtask

  // Evaluate one cycle: check outputs against the model, then clock.
  task automatic step(input string tag);
    bit pc, ifid, idex, exm, mwb, bub, fl, pend, lu, n_hold;
    logic [1:0] f1, f2;
    int n_left;
    logic [11:0] e, o;
    n_left = m_left; n_hold = m_hold;
    lu = ex_memread && ex_regwrite && id_valid && ex_rd != 0 &&
         ((uses(id_opcode, 1) && id_rs1 == ex_rd) || (uses(id_opcode, 2) && id_rs2 == ex_rd));
    if (rst) begin
      {pc, ifid, idex, exm, mwb, fl, pend} = '0; bub = 1; f1 = 0; f2 = 0;
      n_left = 0; n_hold = 0;
    end else begin
      {pc, ifid, idex, exm, mwb} = '1; bub = 0; fl = 0; pend = m_hold;
      f1 = fwd_sel(ex_rs1); f2 = fwd_sel(ex_rs2);
      if (dcache_stall) begin
        {pc, ifid, idex, exm, mwb} = '0;
      end else if (!m_hold && ex_redirect) begin
        fl = 1; bub = 1; pc = !icache_stall; n_hold = icache_stall; n_left = 0;
      end else if (m_hold) begin
        bub = 1;
        if (icache_stall) begin pc = 0; ifid = 0; end
        else begin fl = 1; n_hold = 0; end
      end else if (m_left > 0) begin
        pc = 0; ifid = 0; bub = 1; n_left = m_left - 1;
      end else if (lu) begin
        pc = 0; ifid = 0; bub = 1; n_left = LL - 1;
      end else if (icache_stall) begin
        pc = 0; ifid = 0; bub = 1;
      end
    end
    #2;
    e = {pc, ifid, idex, exm, mwb, bub, fl, pend, f1, f2};
    o = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, bubble, flush, pending, fwd1, fwd2};
    chk({tag, ".ctl"}, 96'(o), 96'(e));
    if (!rst) begin
`ifdef HAZARD_PERF_EN
      chk({tag, ".cnt"}, {stall_cnt, bubble_cnt, flush_cnt}, {m_stall, m_bub, m_fl});
`else
      chk({tag, ".cnt"}, {stall_cnt, bubble_cnt, flush_cnt}, 96'd0);
`endif
    end
    if (!pc_en) pc_low_seen++;
    if (pending) pend_seen++;
    @(posedge clk);
    if (rst) begin
      m_stall = '0; m_bub = '0; m_fl = '0;
    end else begin
      m_stall += CW'(!pc); m_bub += CW'(bub); m_fl += CW'(fl);
    end
    m_left = n_left; m_hold = n_hold;
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    step("rst0");
    step("rst1");
    rst = 0;
    step("idle");

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID -> LOAD_LAT stall cycles.
    pc_low_seen = 0;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
    id_valid = 1; id_opcode = 7'b0110011; id_rs1 = 5; id_rs2 = 1;
    step("lu_hit");
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
    step("lu_wait");
    step("lu_resume");
    step("lu_run");
    chk("lu_pc_low_cycles", 96'(pc_low_seen), 96'd2);

    // No hazard: lui / jal have no sources; rd=x0 never matches.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 5;
    id_opcode = 7'b0110111; step("lu_lui");
    id_opcode = 7'b1101111; step("lu_jal");
    ex_rd = 0; id_opcode = 7'b0110011; id_rs1 = 0; id_rs2 = 0; step("lu_x0");
    idle();

    // Forwarding priority.
    mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1; ex_rs1 = 3; ex_rs2 = 7;
    step("fwd_mem");
    mem_regwrite = 0; step("fwd_wb");
    ex_rs1 = 0; step("fwd_x0");
    idle();

    // Redirect during a 4-cycle I-miss.
    pend_seen = 0;
    ex_redirect = 1; icache_stall = 1; step("redir_cyc");
    ex_redirect = 0;
    for (int i = 0; i < 3; i++) step("redir_hold");
    icache_stall = 0; step("redir_release");
    step("redir_run");
    chk("redir_pending_cycles", 96'(pend_seen), 96'd4);

    // D-cache stall while LU_WAIT owes one bubble.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 4;
    id_valid = 1; id_opcode = 7'b0000011; id_rs1 = 4;
    step("dlu_hit");
    ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
    dcache_stall = 1;
    for (int i = 0; i < 3; i++) step("dlu_dstall");
    dcache_stall = 0;
    step("dlu_wait");
    step("dlu_run");
    idle();

    // Reset while a redirect is held.
    ex_redirect = 1; icache_stall = 1; step("rh_redir");
    ex_redirect = 0; step("rh_hold");
    rst = 1; step("rh_rst");
    rst = 0; icache_stall = 0; step("rh_after");
    chk("rh_pending_after", 96'(pending), 96'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom % 150) == 0;
      dcache_stall = ($urandom % 8) == 0;
      icache_stall = ($urandom % 4) == 0;
      ex_redirect  = ($urandom % 7) == 0;
      id_valid     = ($urandom % 4) != 0;
      id_opcode    = OPS[$urandom % 8];
      id_rs1       = AW'($urandom % 4);
      id_rs2       = AW'($urandom % 4);
      ex_rd        = AW'($urandom % 4);
      ex_memread   = ($urandom % 2) == 0;
      ex_regwrite  = ($urandom % 4) != 0;
      mem_rd       = AW'($urandom % 4);
      mem_regwrite = ($urandom % 2) == 0;
      wb_rd        = AW'($urandom % 4);
      wb_regwrite  = ($urandom % 2) == 0;
      ex_rs1       = AW'($urandom % 4);
      ex_rs2       = AW'($urandom % 4);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
